// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path and the sensor crossbar.
//   tx_state_t : serializer states (IDLE, START, DATA, STOP)
//   DATA_BITS  : payload bits per 8N1 frame
//   CR, T, D   : ASCII bytes the crossbar emits and the TX path carries
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] T  = 8'h54;
    localparam logic [7:0] D  = 8'h44;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with registered full/empty flags and an occupancy count.
// The head entry is always visible on data_o; a pop simply advances past it.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push_i/data_i : write request and data (ignored while full)
//   pop_i/data_o  : read request (ignored while empty) and head entry
//   full_o        : count == DEPTH
//   empty_o       : count == 0
//   count_o       : current occupancy, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    // A push is refused while full even if a pop frees a slot on the same
    // edge; this keeps tx_ready a pure function of registered state.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
    // the modulo-DEPTH wrap fall out of the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Buffers bytes from the crossbar and serialises them as 8N1 frames, LSB
// first. Bursts are accepted at clock rate and drained at baud rate.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   tx_data    : byte to transmit
//   tx_valid   : tx_data valid this cycle
//   tx_ready   : FIFO can accept (not full)
//   tx_serial  : registered UART TX line, idle high
//   tx_busy    : frame on the line or bytes still buffered
//   fifo_count : current FIFO occupancy
//   overflow   : sticky, set when tx_valid is seen while not ready
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_serial_q, tx_serial_d;
    logic                   overflow_q;
    logic                   baud_last;
    logic                   fifo_pop;
    logic [7:0]             fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_valid),
        .data_i  (tx_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_last = (baud_cnt_q == BAUD_LAST);

    // The line level for the next cycle is computed here and registered, so
    // the pin follows the state change on the same edge without glitches.
    // STOP pops straight into START so back-to-back frames have no gap.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tx_serial_d = tx_serial_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_serial_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    shift_d     = fifo_head;
                    baud_cnt_d  = '0;
                    state_d     = START;
                    tx_serial_d = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_d  = '0;
                    bit_idx_d   = '0;
                    state_d     = DATA;
                    tx_serial_d = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d     = STOP;
                        tx_serial_d = 1'b1;
                    end else begin
                        shift_d     = shift_q >> 1;
                        bit_idx_d   = bit_idx_q + BIT_W'(1);
                        tx_serial_d = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        shift_d     = fifo_head;
                        state_d     = START;
                        tx_serial_d = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        tx_serial_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                tx_serial_d = 1'b1;
            end
        endcase
    end

    // Reset drives the line high at once, aborting any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_serial_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_serial_q <= tx_serial_d;
        end
    end

    // Diagnostic only: records that the producer offered data while full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (tx_valid && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign tx_ready  = !fifo_full;
    assign tx_serial = tx_serial_q;
    assign tx_busy   = (state_q != IDLE) || !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Drives uart_tx_fifo with directed and random byte streams and compares
// every output, every cycle, against a timeline model of the transmitter:
// a queue of buffered bytes plus the position inside the current frame.
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 40;
    localparam int BAUD   = 10;
    localparam int DEPTH  = 4;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * CPB;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic [7:0] txData   = 8'h00;
    logic       txValid  = 1'b0;
    logic       txReady;
    logic       txSerial;
    logic       txBusy;
    logic [2:0] fifoCount;
    logic       overflow;

    int compareCount = 0;
    int failCount    = 0;

    // Reference model: bytes waiting, cycle index within the frame on the
    // line (-1 when the line is idle), byte being sent, sticky overflow.
    byte unsigned mq[$];
    int           mFrame    = -1;
    logic [7:0]   mCur      = 8'h00;
    bit           mOverflow = 1'b0;
    bit           mAccepted = 1'b0;

    uart_tx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (txData),
        .tx_valid   (txValid),
        .tx_ready   (txReady),
        .tx_serial  (txSerial),
        .tx_busy    (txBusy),
        .fifo_count (fifoCount),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string tag);
        compareCount++;
        failCount++;
        $error("[TB] FAIL %s observed=timeout expected=completion at %0t", tag, $time);
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        txValid = valid;
        txData  = data;
    endtask

    function automatic void modelReset();
        mq.delete();
        mFrame    = -1;
        mCur      = 8'h00;
        mOverflow = 1'b0;
        mAccepted = 1'b0;
    endfunction

    // One clock edge: a frame occupies FRAME cycles; when the line is free
    // (idle, or the last cycle of a frame) the oldest byte starts next.
    // Pop and accept both look at the occupancy before the edge.
    function automatic void modelEdge();
        bit acceptNow;
        acceptNow = txValid && (mq.size() < DEPTH);
        if (txValid && (mq.size() == DEPTH)) mOverflow = 1'b1;
        if ((mFrame < 0) || (mFrame == FRAME - 1)) begin
            if (mq.size() > 0) begin
                mCur   = mq.pop_front();
                mFrame = 0;
            end else begin
                mFrame = -1;
            end
        end else begin
            mFrame++;
        end
        if (acceptNow) mq.push_back(txData);
        mAccepted = acceptNow;
    endfunction

    function automatic logic expectedLine();
        int k;
        if (mFrame < 0) return 1'b1;
        k = mFrame;
        if (k < CPB) return 1'b0;
        if (k < 9 * CPB) return mCur[3'((k - CPB) / CPB)];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("line",  32'(txSerial),  32'(expectedLine()));
        checkOutput("busy",  32'(txBusy),    32'((mFrame >= 0) || (mq.size() > 0)));
        checkOutput("count", 32'(fifoCount), 32'(mq.size()));
        checkOutput("ready", 32'(txReady),   32'(mq.size() < DEPTH));
        checkOutput("ovf",   32'(overflow),  32'(mOverflow));
    endtask

    task automatic pushByte(input logic [7:0] b);
        int n;
        n = 0;
        applyStimulus(1'b1, b);
        do begin
            tick();
            n++;
        end while (!mAccepted && n < 200);
        if (!mAccepted) reportTimeout("push");
        applyStimulus(1'b0, b);
    endtask

    task automatic drainIdle();
        int n;
        n = 0;
        while (((mFrame >= 0) || (mq.size() > 0)) && n < 2000) begin
            tick();
            n++;
        end
        if ((mFrame >= 0) || (mq.size() > 0)) reportTimeout("drain");
        tick();
    endtask

    initial begin
        int n;
        logic [7:0] base;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst line",  32'(txSerial),  32'd1);
        checkOutput("rst ready", 32'(txReady),   32'd1);
        checkOutput("rst busy",  32'(txBusy),    32'd0);
        checkOutput("rst count", 32'(fifoCount), 32'd0);
        checkOutput("rst ovf",   32'(overflow),  32'd0);
        modelReset();
        rst = 1'b1;

        // 1: single 'T' frame, 40 cycles then idle
        $display("[TB] single byte");
        pushByte(uart_pkg::T);
        tick();
        checkOutput("t1 start", 32'(txSerial), 32'd0);
        repeat (39) tick();
        checkOutput("t1 stop", 32'(txSerial), 32'd1);
        checkOutput("t1 busy", 32'(txBusy), 32'd1);
        tick();
        checkOutput("t1 idle", 32'(txBusy), 32'd0);
        drainIdle();

        // 2: burst "25\r", contiguous frames
        $display("[TB] burst");
        pushByte(8'h32);
        pushByte(8'h35);
        pushByte(uart_pkg::CR);
        checkOutput("t2 peak", 32'(fifoCount), 32'd2);
        drainIdle();

        // 3: fill to full, then overflow and late acceptance
        $display("[TB] full");
        for (int i = 0; i < 5; i++) pushByte(8'h41 + 8'(i));
        checkOutput("t3 full", 32'(txReady), 32'd0);
        applyStimulus(1'b1, 8'h46);
        tick();
        checkOutput("t3 ovf", 32'(overflow), 32'd1);
        n = 0;
        while (!mAccepted && n < 200) begin
            tick();
            n++;
        end
        if (!mAccepted) reportTimeout("t3 accept");
        applyStimulus(1'b0, 8'h00);
        drainIdle();

        // 4: ten distinct bytes in groups of three across the pointer wrap
        $display("[TB] wrap");
        base = 8'($urandom_range(0, 255));
        for (int i = 0; i < 10; i++) begin
            pushByte(base + 8'(i * 23));
            if ((i % 3) == 2 || i == 9) drainIdle();
        end

        // 6: push on the STOP->START pop edge with two bytes queued
        $display("[TB] push on pop edge");
        pushByte(8'hC3);
        pushByte(8'h5A);
        pushByte(8'h0F);
        n = 0;
        while (mFrame != FRAME - 1 && n < 200) begin
            tick();
            n++;
        end
        if (mFrame != FRAME - 1) reportTimeout("t6 align");
        checkOutput("t6 pre", 32'(fifoCount), 32'd2);
        pushByte(8'h99);
        checkOutput("t6 held", 32'(fifoCount), 32'd2);
        drainIdle();

        // 5: reset during a data bit of 0xAA with two bytes queued
        $display("[TB] reset mid-frame");
        pushByte(8'hAA);
        pushByte(8'h11);
        pushByte(8'h22);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("t5 line",  32'(txSerial),  32'd1);
        checkOutput("t5 count", 32'(fifoCount), 32'd0);
        checkOutput("t5 busy",  32'(txBusy),    32'd0);
        checkOutput("t5 ready", 32'(txReady),   32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5 ovf", 32'(overflow), 32'd0);
        repeat (50) tick();

        // Random traffic; a refused byte is held until accepted
        $display("[TB] random");
        for (int c = 0; c < 500; c++) begin
            if (!(txValid && !mAccepted)) begin
                applyStimulus(($urandom_range(0, 3) == 0), 8'($urandom));
            end
            tick();
        end
        applyStimulus(1'b0, 8'h00);
        drainIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
